// File: rtl/alu_issue_if.sv
// Command handshake into the ALU issue stage and the registered control bundle it drives.
// The master side produces commands; the slave side (the issue stage) answers and drives the ALU.
interface alu_issue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [1:0] alu_operation;
    logic       ENABLE;
    logic       busy;
    logic       div_zero_err;
    logic [7:0] issued_count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready, operand_a, operand_b, alu_operation,
        input  ENABLE, busy, div_zero_err, issued_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready, operand_a, operand_b, alu_operation,
        output ENABLE, busy, div_zero_err, issued_count
    );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: queues commands in a small FIFO and issues them one at a time,
// holding off for a per-operation latency after each ENABLE strobe.
module alu_issue #(
    parameter int DEPTH      = 4,
    parameter int ADDSUB_LAT = 1,
    parameter int MULDIV_LAT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    alu_issue_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int MAX_LAT = (ADDSUB_LAT > MULDIV_LAT) ? ADDSUB_LAT : MULDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MULT = 2'b10, OP_DIV = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          div_reject;
    logic          push;
    logic          pop;
    logic          load_wait;
    logic [CW-1:0] wait_ctr;
    state_e        state;
    state_e        next_state;
    cmd_t          head;

    // Readiness looks only at registered occupancy, so a pop while full never opens the door early.
    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign bus.cmd_ready = !full && !RESET;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign div_reject    = accept && (bus.cmd_op == OP_DIV) && (bus.cmd_b == 8'h00);
    assign push          = accept && !div_reject;
    assign head          = mem[rd_ptr];
    assign bus.busy      = !empty || (state != IDLE);

    // NOTE: the storage array has no reset; pointers and occupancy alone decide which entries are live.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end

    // NOTE: every sequential process uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps combinational blocks free of latches.
        next_state = state;
        unique case (state)
            IDLE:    if (!empty) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_ctr == CW'(1)) next_state = empty ? IDLE : ISSUE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        load_wait = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            ISSUE:   load_wait = 1'b1;
            WAIT:    pop = (wait_ctr == CW'(1)) && !empty;
            default: ;
        endcase
    end

    // The hold-off length follows the opcode just issued, which alu_operation still carries.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_ctr <= '0;
        end else if (load_wait) begin
            wait_ctr <= bus.alu_operation[1] ? CW'(MULDIV_LAT) : CW'(ADDSUB_LAT);
        end else if (state == WAIT) begin
            wait_ctr <= wait_ctr - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.operand_a     <= '0;
            bus.operand_b     <= '0;
            bus.alu_operation <= '0;
            bus.ENABLE        <= 1'b0;
            bus.div_zero_err  <= 1'b0;
            bus.issued_count  <= '0;
        end else begin
            bus.ENABLE       <= pop;
            bus.div_zero_err <= div_reject;
            if (pop) begin
                bus.operand_a     <= head.a;
                bus.operand_b     <= head.b;
                bus.alu_operation <= head.op;
            end
            if (load_wait) bus.issued_count <= bus.issued_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model built on a command queue and issue times.
module tb_alu_issue;
    localparam int DEPTH      = 4;
    localparam int ADDSUB_LAT = 1;
    localparam int MULDIV_LAT = 3;

    typedef struct packed {
        bit [1:0] op;
        bit [7:0] a;
        bit [7:0] b;
    } cmd_t;

    logic clk;
    logic rst;

    alu_issue_if bus ();

    alu_issue #(
        .DEPTH      (DEPTH),
        .ADDSUB_LAT (ADDSUB_LAT),
        .MULDIV_LAT (MULDIV_LAT)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending commands and when the previous one issued.
    cmd_t     mq[$];
    int       e         = 0;
    int       last_e    = 0;
    bit [1:0] last_op   = 2'b00;
    bit       have_last = 1'b0;
    bit       exp_en    = 1'b0;
    bit       exp_dz    = 1'b0;
    bit       exp_busy  = 1'b0;
    cmd_t     exp_cmd   = '0;
    bit [7:0] cnt       = 8'd0;
    int       acc_total = 0;

    // Observations used by the directed scenarios.
    int en_edges[$];
    int dz_seen   = 0;
    bit saw_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat(input bit [1:0] op);
        return op[1] ? MULDIV_LAT : ADDSUB_LAT;
    endfunction

    task automatic step(input bit v, input bit [1:0] op, input bit [7:0] a, input bit [7:0] b,
                        input bit r);
        bit   rdy;
        bit   acc;
        bit   issue;
        cmd_t h;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        rst           = r;
        #1;
        rdy = !r && (mq.size() < DEPTH);
        check("cmd_ready", bus.cmd_ready, rdy);
        if (v && !bus.cmd_ready) saw_stall = 1'b1;
        e++;
        if (r) begin
            mq.delete();
            cnt       = 8'd0;
            exp_en    = 1'b0;
            exp_dz    = 1'b0;
            exp_cmd   = '0;
            have_last = 1'b0;
        end else begin
            acc = v && rdy;
            if (exp_en) cnt = cnt + 8'd1;
            issue = (mq.size() > 0) && (!have_last || e >= last_e + 1 + lat(last_op));
            exp_en = issue;
            if (issue) begin
                h         = mq.pop_front();
                exp_cmd   = h;
                last_e    = e;
                last_op   = h.op;
                have_last = 1'b1;
            end
            exp_dz = acc && (op == 2'b11) && (b == 8'h00);
            if (acc) acc_total++;
            if (acc && !exp_dz) mq.push_back({op, a, b});
        end
        exp_busy = (mq.size() > 0) || (have_last && e <= last_e + lat(last_op));
        @(posedge clk);
        #1;
        check("ENABLE", bus.ENABLE, exp_en);
        check("operands", {bus.alu_operation, bus.operand_a, bus.operand_b}, exp_cmd);
        check("issued_count", bus.issued_count, cnt);
        check("div_zero_err", bus.div_zero_err, exp_dz);
        check("busy", bus.busy, exp_busy);
        if (bus.ENABLE) en_edges.push_back(e);
        if (bus.div_zero_err) dz_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        en_edges.delete();
        dz_seen   = 0;
        saw_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int target;
        int offs[4];
        offs = '{1, 3, 5, 9};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        rst           = 1'b1;

        // Reset state, then a lone ADD of -5 and -2.
        do_reset(2);
        idle(1);
        step(1'b1, 2'b00, 8'hFB, 8'hFE, 1'b0);
        idle(3);
        check("single_opa", bus.operand_a, 8'hFB);
        check("single_opb", bus.operand_b, 8'hFE);
        check("single_op", bus.alu_operation, 2'b00);
        check("single_count", bus.issued_count, 8'd1);
        check("single_busy", bus.busy, 1'b0);

        // SUB, SUB, MULT, ADD back to back: issue spacing follows each latency.
        do_reset(1);
        n0 = e + 1;
        step(1'b1, 2'b01, 8'd10, 8'd1, 1'b0);
        step(1'b1, 2'b01, 8'd20, 8'd2, 1'b0);
        step(1'b1, 2'b10, 8'd30, 8'd3, 1'b0);
        step(1'b1, 2'b00, 8'd40, 8'd4, 1'b0);
        idle(12);
        check("mix_pulses", en_edges.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < en_edges.size()) check("mix_rise", en_edges[i] - n0, offs[i]);
        end
        check("mix_count", bus.issued_count, 8'd4);

        // Six MULTs with valid held: FIFO fills, back-pressure, 4-cycle spacing.
        do_reset(1);
        target = acc_total + 6;
        for (int k = 0; k < 200 && acc_total < target; k++)
            step(1'b1, 2'b10, 8'(acc_total), 8'd7, 1'b0);
        check("mult_accepted", acc_total, target);
        idle(30);
        check("mult_stall", saw_stall, 1'b1);
        check("mult_pulses", en_edges.size(), 6);
        for (int i = 1; i < en_edges.size(); i++)
            check("mult_spacing", en_edges[i] - en_edges[i-1], 4);
        check("mult_count", bus.issued_count, 8'd6);

        // Divide by zero is rejected, the following valid divide still issues.
        do_reset(1);
        step(1'b1, 2'b11, 8'd21, 8'd0, 1'b0);
        step(1'b1, 2'b11, 8'd21, 8'd3, 1'b0);
        idle(10);
        check("div_err_pulses", dz_seen, 1);
        check("div_pulses", en_edges.size(), 1);
        check("div_opa", bus.operand_a, 8'd21);
        check("div_opb", bus.operand_b, 8'd3);
        check("div_op", bus.alu_operation, 2'b11);
        check("div_count", bus.issued_count, 8'd1);

        // Reset during WAIT with three commands still queued.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 8'(i + 1), 8'd5, 1'b0);
        do_reset(2);
        idle(12);
        check("rst_pulses", en_edges.size(), 0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", bus.issued_count, 8'd0);
        check("rst_enable", bus.ENABLE, 1'b0);

        // 256 ADDs: issued_count wraps back to zero.
        do_reset(1);
        target = acc_total + 256;
        for (int k = 0; k < 2000 && acc_total < target; k++)
            step(1'b1, 2'b00, 8'(k), 8'(k * 3), 1'b0);
        check("wrap_accepted", acc_total, target);
        idle(8);
        check("wrap_pulses", en_edges.size(), 256);
        check("wrap_count", bus.issued_count, 8'd0);

        // Random traffic with occasional resets and zero divisors.
        do_reset(1);
        for (int k = 0; k < 3000; k++) begin
            bit       v;
            bit [1:0] op;
            bit [7:0] a;
            bit [7:0] b;
            bit       r;
            v  = ($urandom_range(0, 9) < 6);
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            r  = ($urandom_range(0, 299) == 0);
            step(v, op, a, b, r);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
